// File: rtl/data_send_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared DataSend transmitter.
interface data_send_arbiter_if #(
  parameter int unsigned NUMREQ = 4,
  parameter int unsigned W      = 56
);
  logic [NUMREQ-1:0]   reqIn;
  logic [NUMREQ*W-1:0] dataIn;
  logic [NUMREQ-1:0]   grantOut;
  logic [NUMREQ-1:0]   ackOut;
  logic [NUMREQ-1:0]   errOut;
  logic                busy;
  logic                txEnable;
  logic [W-1:0]        txData;
  logic                txDone;

  // Arbiter side
  modport master (
    input  reqIn, dataIn, txDone,
    output grantOut, ackOut, errOut, busy, txEnable, txData
  );

  // Requester / transmitter side
  modport slave (
    output reqIn, dataIn, txDone,
    input  grantOut, ackOut, errOut, busy, txEnable, txData
  );
endinterface

// File: rtl/data_send_arbiter.sv
// Round-robin arbiter sharing one DataSend frame transmitter between NUMREQ requesters.
module data_send_arbiter #(
  parameter int unsigned NUMREQ    = 4,
  parameter int unsigned BYTENUM   = 7,
  parameter int unsigned CLKFREQ   = 100_000_000,
  parameter int unsigned BAUDRATE  = 115200,
  parameter int unsigned GAPCYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  data_send_arbiter_if.master bus
);

  localparam int unsigned W          = BYTENUM * 8;
  localparam int unsigned TIMEOUTCYC = 2 * BYTENUM * 10 * (CLKFREQ / BAUDRATE);
  localparam int unsigned TO_W       = (TIMEOUTCYC > 1) ? $clog2(TIMEOUTCYC) : 1;
  localparam int unsigned GAP_W      = (GAPCYCLES > 1) ? $clog2(GAPCYCLES) : 1;
  localparam int unsigned PTR_W      = $clog2(NUMREQ);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUTCYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAPCYCLES == 0) ? 0 : GAPCYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUMREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NUMREQ-1:0] grant_q, grant_d;
  logic [NUMREQ-1:0] ack_q, ack_d;
  logic [NUMREQ-1:0] err_q, err_d;
  logic              busy_q, busy_d;
  logic              tx_en_q, tx_en_d;
  logic [W-1:0]      tx_data_q, tx_data_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic [NUMREQ-1:0] eligible_c;
  logic              win_found_c;
  logic [PTR_W-1:0]  win_idx_c;
  logic              done_c;
  logic              timeout_c;
  logic              finish_c;
  logic              gap_end_c;

  // Round-robin pick: first eligible requester at or above the pointer, wrapping.
  // The requester whose ack/err pulse is still visible is masked so it cannot be re-granted back-to-back.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    eligible_c  = bus.reqIn & ~ack_q & ~err_q;
    win_found_c = 1'b0;
    win_idx_c   = '0;
    for (int unsigned i = 0; i < NUMREQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUMREQ) begin
        cand = cand - NUMREQ;
      end
      if (!win_found_c && eligible_c[PTR_W'(cand)]) begin
        win_found_c = 1'b1;
        win_idx_c   = PTR_W'(cand);
      end
    end
  end

  // Transfer-end events; a done on the timeout edge takes priority over the timeout.
  always_comb begin
    done_c    = (state_q == ST_SEND) && bus.txDone;
    timeout_c = (state_q == ST_SEND) && !bus.txDone && (to_cnt_q == TO_LAST);
    finish_c  = done_c || timeout_c;
    gap_end_c = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found_c) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (finish_c) begin
          state_d = (GAPCYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_end_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; ack/err are single-cycle pulses, everything else holds by default.
  always_comb begin
    grant_d   = grant_q;
    ack_d     = '0;
    err_d     = '0;
    busy_d    = busy_q;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    ptr_d     = ptr_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found_c) begin
          tx_data_d = bus.dataIn[32'(win_idx_c) * W +: W];
          grant_d   = NUMREQ'(1) << win_idx_c;
          tx_en_d   = 1'b1;
          busy_d    = 1'b1;
          ptr_d     = (win_idx_c == PTR_LAST) ? '0 : win_idx_c + PTR_W'(1);
          to_cnt_d  = '0;
        end
      end
      ST_SEND: begin
        if (finish_c) begin
          tx_en_d   = 1'b0;
          grant_d   = '0;
          ack_d     = done_c ? grant_q : '0;
          err_d     = timeout_c ? grant_q : '0;
          busy_d    = (GAPCYCLES != 0);
          gap_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_end_c) begin
          busy_d = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        tx_en_d = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      ptr_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      ptr_q     <= ptr_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign bus.grantOut = grant_q;
  assign bus.ackOut   = ack_q;
  assign bus.errOut   = err_q;
  assign bus.busy     = busy_q;
  assign bus.txEnable = tx_en_q;
  assign bus.txData   = tx_data_q;

endmodule

// File: tb/tb_data_send_arbiter.sv
// Scoreboard bench for data_send_arbiter: stimulus queues expected grants/completions, a monitor checks them.
module tb_data_send_arbiter;

  localparam int unsigned NR   = 4;
  localparam int unsigned W    = 56;
  localparam int unsigned GAP  = 16;
  localparam int          TOUT = 1400;

  typedef struct {
    logic [NR-1:0] grant;
    logic [W-1:0]  data;
  } exp_grant_t;

  typedef struct {
    logic [NR-1:0] ack;
    logic [NR-1:0] err;
    int            lat;
  } exp_done_t;

  logic clk;
  logic reset;

  data_send_arbiter_if #(.NUMREQ(NR), .W(W)) b1 ();
  data_send_arbiter_if #(.NUMREQ(NR), .W(W)) b2 ();

  data_send_arbiter #(
    .NUMREQ(NR), .BYTENUM(7), .CLKFREQ(1_000_000), .BAUDRATE(100_000), .GAPCYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .bus(b1)
  );

  data_send_arbiter #(
    .NUMREQ(NR), .BYTENUM(7), .CLKFREQ(1_000_000), .BAUDRATE(100_000), .GAPCYCLES(0)
  ) dut_nogap (
    .clk(clk), .reset(reset), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_grant_t gq[$];
  exp_done_t  dq[$];
  logic [W-1:0] word [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input int i, input logic [W-1:0] w);
    word[i] = w;
    b1.dataIn[i*W +: W] = w;
  endtask

  task automatic wait_rise(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (b1.txEnable) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_txEnable_rise: timed out after %0d cycles", budget);
    end
  endtask

  // One granted transfer of requester idx, completed by txDone; latency = n_wait + 1 cycles.
  task automatic transfer(input int idx, input int n_wait, input bit drop);
    exp_grant_t eg;
    exp_done_t  ed;
    bit         ok;
    eg.grant = NR'(1) << idx;
    eg.data  = word[idx];
    ed.ack   = NR'(1) << idx;
    ed.err   = '0;
    ed.lat   = n_wait + 1;
    gq.push_back(eg);
    dq.push_back(ed);
    wait_rise(64, ok);
    if (ok) begin
      repeat (n_wait) @(negedge clk);
      b1.txDone = 1'b1;
      @(negedge clk);
      b1.txDone = 1'b0;
      if (drop) b1.reqIn[idx] = 1'b0;
    end
  endtask

  // Monitor: checks every grant, every ack/err pulse and the busy tail of each gap against the queues.
  int            cyc = 0;
  int            rise_cyc = 0;
  int            fall_cyc = 0;
  bit            in_send = 1'b0;
  bit            fell = 1'b0;
  bit            unstable = 1'b0;
  logic          prev_en = 1'b0;
  logic          prev_busy = 1'b0;
  logic [W-1:0]  cur_data;
  logic [NR-1:0] cur_grant;

  always @(negedge clk) begin
    exp_grant_t eg;
    exp_done_t  ed;
    cyc++;
    if (reset) begin
      in_send = 1'b0;
      fell    = 1'b0;
    end else begin
      if (b1.txEnable && !prev_en) begin
        total++;
        if (gq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_grant: grant=%b data=%h", b1.grantOut, b1.txData);
        end else begin
          eg = gq.pop_front();
          if (b1.grantOut !== eg.grant || b1.txData !== eg.data) begin
            bad++;
            $display("FAIL grant: got grant=%b data=%h expected grant=%b data=%h",
                     b1.grantOut, b1.txData, eg.grant, eg.data);
          end
        end
        rise_cyc  = cyc;
        cur_data  = b1.txData;
        cur_grant = b1.grantOut;
        unstable  = 1'b0;
        in_send   = 1'b1;
      end else if (in_send && b1.txEnable) begin
        if (b1.txData !== cur_data || b1.grantOut !== cur_grant) unstable = 1'b1;
      end
      if ((b1.ackOut | b1.errOut) != '0) begin
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: ack=%b err=%b", b1.ackOut, b1.errOut);
        end else begin
          ed = dq.pop_front();
          if (b1.ackOut !== ed.ack || b1.errOut !== ed.err || (cyc - rise_cyc) != ed.lat ||
              unstable || b1.txEnable !== 1'b0 || b1.grantOut !== '0) begin
            bad++;
            $display("FAIL done: got ack=%b err=%b lat=%0d unstable=%0d en=%b expected ack=%b err=%b lat=%0d unstable=0 en=0",
                     b1.ackOut, b1.errOut, cyc - rise_cyc, unstable, b1.txEnable, ed.ack, ed.err, ed.lat);
          end
        end
        in_send  = 1'b0;
        fall_cyc = cyc;
        fell     = 1'b1;
      end
      if (!b1.busy && prev_busy && fell) begin
        chk("gap_length", 64'(cyc - fall_cyc), 64'(GAP));
        fell = 1'b0;
      end
    end
    prev_en   = b1.txEnable;
    prev_busy = b1.busy;
  end

  initial begin
    bit ok;
    int lows;
    reset     = 1'b1;
    b1.reqIn  = '0;
    b1.dataIn = '0;
    b1.txDone = 1'b0;
    b2.reqIn  = '0;
    b2.txDone = 1'b0;
    set_word(0, 56'hA0A1A2A3A4A5A6);
    set_word(1, 56'h11223344556677);
    set_word(2, 56'hC0C1C2C3C4C5C6);
    set_word(3, 56'hD0D1D2D3D4D5D6);
    b2.dataIn = {56'h3333, 56'h2222, 56'h5A5A5A5A5A5A5A, 56'h1111};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(b1.grantOut), 64'd0);
    chk("rst_ack", 64'(b1.ackOut), 64'd0);
    chk("rst_err", 64'(b1.errOut), 64'd0);
    chk("rst_busy", 64'(b1.busy), 64'd0);
    chk("rst_txen", 64'(b1.txEnable), 64'd0);
    chk("rst_txdata", 64'(b1.txData), 64'd0);
    chk("rst_nogap_txen", 64'(b2.txEnable), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1. Single request, dataIn changed mid-transfer, txDone 50 cycles after rise
    begin
      exp_grant_t eg;
      exp_done_t  ed;
      eg.grant = 4'b0010; eg.data = 56'h11223344556677;
      ed.ack = 4'b0010; ed.err = 4'b0000; ed.lat = 50;
      gq.push_back(eg);
      dq.push_back(ed);
    end
    b1.reqIn = 4'b0010;
    @(negedge clk);
    chk("req_to_txen_1cyc", 64'(b1.txEnable), 64'd1);
    repeat (20) @(negedge clk);
    set_word(1, 56'hFFEEDDCCBBAA99);
    repeat (29) @(negedge clk);
    b1.txDone = 1'b1;
    @(negedge clk);
    b1.txDone = 1'b0;
    b1.reqIn  = '0;
    lows = 0;
    repeat (GAP) begin
      @(negedge clk);
      if (!b1.txEnable) lows++;
    end
    chk("gap_txen_low", 64'(lows), 64'(GAP));
    repeat (10) @(negedge clk);

    // 2. All four after reset: order 0,1,2,3
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    b1.reqIn = 4'b1111;
    for (int i = 0; i < 4; i++) transfer(i, 10, 1'b1);
    repeat (24) @(negedge clk);

    // 3. Fairness: 0 and 2 held -> 0,2,0,2,0,2
    b1.reqIn = 4'b0101;
    for (int i = 0; i < 6; i++) transfer((i % 2) * 2, 5, 1'b0);
    b1.reqIn = '0;
    repeat (24) @(negedge clk);

    // 4. Timeout on requester 3, then pointer wraps to 0
    begin
      exp_grant_t eg;
      exp_done_t  ed;
      eg.grant = 4'b1000; eg.data = word[3];
      ed.ack = 4'b0000; ed.err = 4'b1000; ed.lat = TOUT;
      gq.push_back(eg);
      dq.push_back(ed);
    end
    b1.reqIn = 4'b1000;
    wait_rise(8, ok);
    ok = 1'b0;
    for (int i = 0; i < TOUT + 100; i++) begin
      @(negedge clk);
      if ((b1.ackOut | b1.errOut) != '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("timeout_seen", 64'(ok), 64'd1);
    b1.reqIn = '0;
    repeat (24) @(negedge clk);
    b1.reqIn = 4'b0011;
    transfer(0, 6, 1'b1);
    transfer(1, 6, 1'b1);
    repeat (24) @(negedge clk);

    // 5. GAPCYCLES=0: done on the timeout edge wins, served requester not re-granted in its ack cycle
    b2.reqIn = 4'b0010;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b2.txEnable) begin
        ok = 1'b1;
        break;
      end
    end
    chk("nogap_rise", 64'(ok), 64'd1);
    chk("nogap_grant", 64'(b2.grantOut), 64'b0010);
    chk("nogap_data", 64'(b2.txData), 64'h5A5A5A5A5A5A5A);
    repeat (TOUT - 1) @(negedge clk);
    b2.txDone = 1'b1;
    @(negedge clk);
    b2.txDone = 1'b0;
    chk("nogap_tie_ack", 64'(b2.ackOut), 64'b0010);
    chk("nogap_tie_err", 64'(b2.errOut), 64'd0);
    chk("nogap_tie_txen", 64'(b2.txEnable), 64'd0);
    chk("nogap_tie_busy", 64'(b2.busy), 64'd0);
    @(negedge clk);
    chk("nogap_masked_txen", 64'(b2.txEnable), 64'd0);
    chk("nogap_masked_err", 64'(b2.errOut), 64'd0);
    @(negedge clk);
    chk("nogap_regrant_txen", 64'(b2.txEnable), 64'd1);
    chk("nogap_regrant_grant", 64'(b2.grantOut), 64'b0010);
    b2.reqIn = '0;
    repeat (3) @(negedge clk);
    b2.txDone = 1'b1;
    @(negedge clk);
    b2.txDone = 1'b0;
    chk("nogap_second_ack", 64'(b2.ackOut), 64'b0010);
    repeat (4) @(negedge clk);

    // 6. Async reset mid-SEND, then pointer restarts at 0
    begin
      exp_grant_t eg;
      eg.grant = 4'b0010; eg.data = word[1];
      gq.push_back(eg);
    end
    b1.reqIn = 4'b0010;
    wait_rise(8, ok);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_txen", 64'(b1.txEnable), 64'd0);
    chk("arst_grant", 64'(b1.grantOut), 64'd0);
    chk("arst_busy", 64'(b1.busy), 64'd0);
    chk("arst_ack", 64'(b1.ackOut), 64'd0);
    chk("arst_err", 64'(b1.errOut), 64'd0);
    chk("arst_txdata", 64'(b1.txData), 64'd0);
    b1.reqIn = 4'b0110;
    @(negedge clk);
    reset = 1'b0;
    transfer(1, 4, 1'b1);
    transfer(2, 4, 1'b1);
    repeat (24) @(negedge clk);

    chk("grant_queue_empty", 64'(gq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
